nmos_clk_gen: RTL and testbench

//  Two-phase non-overlapping clock-enable generator driving C1 (PHI1) and C2 (PHI2) of all NMOS cells.
//  All cells sample C1/C2 on posedge main_clk, so this block owns main_clk and is the CLK_GEN instance.

---
 rtl/nmos_clk_pkg.sv | 25 ++
 rtl/nmos_clk_phase_cnt.sv | 27 ++
 rtl/nmos_clk_gen.sv | 123 ++++++++++++
 tb/tb_nmos_clk_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nmos_clk_pkg.sv
// Shared types and helpers for the two-phase NMOS clock-enable generator.
// The state set is common to the top-level FSM and to anything that traces it.
package nmos_clk_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 3'd0,
        PHI1  = 3'd1,
        GAP12 = 3'd2,
        PHI2  = 3'd3,
        GAP21 = 3'd4
    } clk_state_t;

    // Number of main_clk cycles spent in a given state; IDLE has no length.
    function automatic int phase_len(clk_state_t st, int p1_len, int p2_len, int gap_len);
        case (st)
            PHI1:         return p1_len;
            PHI2:         return p2_len;
            GAP12, GAP21: return gap_len;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/nmos_clk_phase_cnt.sv
// Phase timer: loads a value on state entry and counts down to zero.
// expired is high while the count is zero, i.e. in the last cycle of a phase.
module nmos_clk_phase_cnt #(
    parameter int TMR_W = 8
) (
    input  logic             main_clk,
    input  logic             main_rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic [TMR_W-1:0] cnt,
    output logic             expired
);

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/nmos_clk_gen.sv
// Two-phase non-overlapping clock-enable generator (CLK_GEN).
// Machine cycle: PHI1 -> GAP12 -> PHI2 -> GAP21, gaps skipped when GAP_LEN=0.
// All outputs are registered from the next-state decode, so C1/C2 never glitch
// and can never be high together.
// Optional feature macro: NMOS_CLK_STEP_EN (single-step from IDLE via step).
module nmos_clk_gen
    import nmos_clk_pkg::*;
#(
    parameter int P1_LEN  = 3,
    parameter int P2_LEN  = 3,
    parameter int GAP_LEN = 1,
    parameter int CNT_W   = 16,
    parameter int TMR_W   = 8
) (
    input  logic             main_clk,
    input  logic             main_rst_n,
    input  logic             run_req,
    input  logic             step,
    output logic             C1,
    output logic             C2,
    output logic             phi1_rise,
    output logic             phi2_fall,
    output logic             cyc_done,
    output logic             idle,
    output logic [CNT_W-1:0] cyc_cnt
);

    // The machine cycle ends in GAP21, or in PHI2 when there are no gaps.
    localparam bit         HAS_GAP  = (GAP_LEN > 0);
    localparam clk_state_t LAST_ST  = HAS_GAP ? GAP21 : PHI2;
    localparam int         LAST_LEN = HAS_GAP ? GAP_LEN : P2_LEN;

    if (P1_LEN < 1 || P2_LEN < 1 || GAP_LEN < 0 ||
        (P1_LEN - 1) >= (1 << TMR_W) || (P2_LEN - 1) >= (1 << TMR_W) ||
        (GAP_LEN - 1) >= (1 << TMR_W)) begin : g_param_check
        $error("nmos_clk_gen: phase lengths out of range for TMR_W");
    end

    clk_state_t       state_reg;
    clk_state_t       state_next;
    logic             step_go;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic [TMR_W-1:0] tmr_cnt;
    logic             tmr_expired;
    logic             entering;
    logic             phi1_rise_next;
    logic             phi2_fall_next;
    logic             cyc_done_next;

`ifdef NMOS_CLK_STEP_EN
    assign step_go = step;
`else
    logic step_unused;
    assign step_unused = step;
    assign step_go     = 1'b0;
`endif

    // Next-state decode; run_req is only consulted in IDLE and at the cycle boundary.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (run_req || step_go) state_next = PHI1;
            PHI1:    if (tmr_expired) state_next = HAS_GAP ? GAP12 : PHI2;
            GAP12:   if (tmr_expired) state_next = PHI2;
            PHI2:    if (tmr_expired) state_next = HAS_GAP ? GAP21 : (run_req ? PHI1 : IDLE);
            GAP21:   if (tmr_expired) state_next = run_req ? PHI1 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Timer reload on every state change; strobes are predicted one cycle ahead.
    always_comb begin
        entering     = (state_next != state_reg);
        tmr_load     = entering;
        tmr_load_val = '0;
        if (state_next != IDLE) begin
            tmr_load_val = TMR_W'(phase_len(state_next, P1_LEN, P2_LEN, GAP_LEN) - 1);
        end
        phi1_rise_next = (state_next == PHI1) && entering;
        phi2_fall_next = (state_next == PHI2) &&
                         (entering ? (P2_LEN == 1) : (tmr_cnt == TMR_W'(1)));
        cyc_done_next  = (state_next == LAST_ST) &&
                         (entering ? (LAST_LEN == 1) : (tmr_cnt == TMR_W'(1)));
    end

    nmos_clk_phase_cnt #(
        .TMR_W(TMR_W)
    ) u_phase_cnt (
        .main_clk  (main_clk),
        .main_rst_n(main_rst_n),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .cnt       (tmr_cnt),
        .expired   (tmr_expired)
    );

    // FSM state, registered phase outputs and completed-cycle counter.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            state_reg <= IDLE;
            C1        <= 1'b0;
            C2        <= 1'b0;
            phi1_rise <= 1'b0;
            phi2_fall <= 1'b0;
            cyc_done  <= 1'b0;
            idle      <= 1'b1;
            cyc_cnt   <= '0;
        end else begin
            state_reg <= state_next;
            C1        <= (state_next == PHI1);
            C2        <= (state_next == PHI2);
            phi1_rise <= phi1_rise_next;
            phi2_fall <= phi2_fall_next;
            cyc_done  <= cyc_done_next;
            idle      <= (state_next == IDLE);
            if (cyc_done) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nmos_clk_gen.sv
// Scoreboard bench for nmos_clk_gen: three instances (default timing, no-gap
// 1/2 timing, 4-bit counter) share run_req/step/reset. A position-in-cycle
// reference model predicts every output each clock.
module tb_nmos_clk_gen;

`ifdef NMOS_CLK_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    typedef struct {
        bit c1, c2, rise, fall, done, idl;
        int cnt;
    } exp_t;

    logic clk, rst_n, run_req, step;
    logic [2:0] c1_w, c2_w, rise_w, fall_w, done_w, idle_w;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;
    int cnt_w [3];

    int total = 0;
    int bad   = 0;

    // model: phase lengths per instance and running position
    int p1 [3] = '{3, 1, 3};
    int p2 [3] = '{3, 2, 3};
    int gp [3] = '{1, 0, 1};
    int cw [3] = '{16, 16, 4};
    bit m_run [3];
    int m_pos [3];
    int m_cnt [3];
    exp_t sb [3][$];

    nmos_clk_gen u_d0 (
        .main_clk(clk), .main_rst_n(rst_n), .run_req(run_req), .step(step),
        .C1(c1_w[0]), .C2(c2_w[0]), .phi1_rise(rise_w[0]), .phi2_fall(fall_w[0]),
        .cyc_done(done_w[0]), .idle(idle_w[0]), .cyc_cnt(cnt0)
    );

    nmos_clk_gen #(.P1_LEN(1), .P2_LEN(2), .GAP_LEN(0)) u_d1 (
        .main_clk(clk), .main_rst_n(rst_n), .run_req(run_req), .step(step),
        .C1(c1_w[1]), .C2(c2_w[1]), .phi1_rise(rise_w[1]), .phi2_fall(fall_w[1]),
        .cyc_done(done_w[1]), .idle(idle_w[1]), .cyc_cnt(cnt1)
    );

    nmos_clk_gen #(.CNT_W(4)) u_d2 (
        .main_clk(clk), .main_rst_n(rst_n), .run_req(run_req), .step(step),
        .C1(c1_w[2]), .C2(c2_w[2]), .phi1_rise(rise_w[2]), .phi2_fall(fall_w[2]),
        .cyc_done(done_w[2]), .idle(idle_w[2]), .cyc_cnt(cnt2)
    );

    assign cnt_w[0] = int'(cnt0);
    assign cnt_w[1] = int'(cnt1);
    assign cnt_w[2] = int'(cnt2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int inst, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d want %0d at %0t", name, inst, act, exp, $time);
        end
    endfunction

    // Expected outputs from the position inside the machine cycle.
    function automatic exp_t predict(int i);
        exp_t e;
        int per;
        per   = p1[i] + p2[i] + 2 * gp[i];
        e.c1   = m_run[i] && (m_pos[i] < p1[i]);
        e.c2   = m_run[i] && (m_pos[i] >= p1[i] + gp[i]) && (m_pos[i] < p1[i] + gp[i] + p2[i]);
        e.rise = m_run[i] && (m_pos[i] == 0);
        e.fall = m_run[i] && (m_pos[i] == p1[i] + gp[i] + p2[i] - 1);
        e.done = m_run[i] && (m_pos[i] == per - 1);
        e.idl  = !m_run[i];
        e.cnt  = m_cnt[i];
        return e;
    endfunction

    // Advance the model by one main_clk edge using the sampled inputs.
    function automatic void model_edge(int i);
        int per;
        per = p1[i] + p2[i] + 2 * gp[i];
        if (!rst_n) begin
            m_run[i] = 1'b0;
            m_pos[i] = 0;
            m_cnt[i] = 0;
        end else if (!m_run[i]) begin
            if (run_req || (STEP_EN && step)) begin
                m_run[i] = 1'b1;
                m_pos[i] = 0;
            end
        end else if (m_pos[i] == per - 1) begin
            m_cnt[i] = (m_cnt[i] + 1) % (1 << cw[i]);
            if (run_req) m_pos[i] = 0;
            else         m_run[i] = 1'b0;
        end else begin
            m_pos[i] = m_pos[i] + 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            model_edge(i);
            sb[i].push_back(predict(i));
        end
        #2;
    endtask

    task automatic check_reset_now();
        for (int i = 0; i < 3; i++) begin
            chk("rst_C1", i, int'(c1_w[i]), 0);
            chk("rst_C2", i, int'(c2_w[i]), 0);
            chk("rst_rise", i, int'(rise_w[i]), 0);
            chk("rst_fall", i, int'(fall_w[i]), 0);
            chk("rst_done", i, int'(done_w[i]), 0);
            chk("rst_idle", i, int'(idle_w[i]), 1);
            chk("rst_cnt", i, cnt_w[i], 0);
        end
    endtask

    // Monitor: pop one expectation per instance on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("overlap", i, int'(c1_w[i] && c2_w[i]), 0);
                if (sb[i].size() > 0) begin
                    e = sb[i].pop_front();
                    chk("C1", i, int'(c1_w[i]), int'(e.c1));
                    chk("C2", i, int'(c2_w[i]), int'(e.c2));
                    chk("phi1_rise", i, int'(rise_w[i]), int'(e.rise));
                    chk("phi2_fall", i, int'(fall_w[i]), int'(e.fall));
                    chk("cyc_done", i, int'(done_w[i]), int'(e.done));
                    chk("idle", i, int'(idle_w[i]), int'(e.idl));
                    chk("cyc_cnt", i, cnt_w[i], e.cnt);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int hold;
        rst_n   = 1'b1;
        run_req = 1'b0;
        step    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 1'b0;
            m_pos[i] = 0;
            m_cnt[i] = 0;
        end
        #1 rst_n = 1'b0;
        #1 check_reset_now();
        repeat (3) tick();
        rst_n   = 1'b1;
        run_req = 1'b1;
        $display("phase: free-run from reset");
        repeat (160) tick();

        $display("phase: random run_req/step");
        for (int s = 0; s < 60; s++) begin
            run_req = ($urandom_range(0, 2) == 0);
            hold    = $urandom_range(1, 25);
            for (int j = 0; j < hold; j++) begin
                step = ($urandom_range(0, 5) == 0);
                tick();
            end
            step = 1'b0;
        end

        $display("phase: async reset during C2");
        run_req = 1'b0;
        repeat (20) tick();
        run_req = 1'b1;
        repeat (6) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_now();
        for (int i = 0; i < 3; i++) begin
            sb[i].delete();
            m_run[i] = 1'b0;
            m_pos[i] = 0;
            m_cnt[i] = 0;
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();

        run_req = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
